// File: rtl/rv4028_bus_pkg.sv
// rv4028_bus_pkg: arbiter state encoding and default timing constants
package rv4028_bus_pkg;
    typedef enum logic [2:0] {CPU_OWN, WAIT_ACK, TURN, GRANT, RETURN} arb_state_t;
    localparam int DEF_TURN_CYCLES = 1;
    localparam int DEF_HOLD_MAX    = 1024;
endpackage

// File: rtl/rv4028_sync_n.sv
// rv4028_sync_n: multi-flop synchroniser for an active-low async input, resets to idle (1)
module rv4028_sync_n #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_n,
    output logic q_n
);
    logic [STAGES-1:0] ff;
    // shift the raw level through the chain; reset parks every flop at idle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ff <= '1;
        else ff <= {ff[STAGES-2:0], d_n};
    assign q_n = ff[STAGES-1];
endmodule

// File: rtl/rv4028_bus_arbiter.sv
// rv4028_bus_arbiter: round-robin hand-off of the shared bus from the core to NUM_REQ masters; RV4028_ARB_TIMEOUT_EN adds a HOLD_MAX grant limit
module rv4028_bus_arbiter
    import rv4028_bus_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int HOLD_MAX    = DEF_HOLD_MAX,
    localparam int OW         = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] ext_busrq_n,
    output logic [NUM_REQ-1:0] ext_busack_n,
    output logic               core_busrq_n,
    input  logic               core_busack_n,
    output logic               core_drive_en,
    output logic [OW-1:0]      owner,
    output logic               grant_valid,
    output logic               timeout_flag
);
    arb_state_t state, state_next;
    logic [NUM_REQ-1:0] req_n, req, req_eff;
    logic [OW-1:0] rr, rr_next, owner_next, win;
    logic [3:0] turn_cnt, turn_next;
    logic revoke;

    if (NUM_REQ < 1 || NUM_REQ > 8 || SYNC_STAGES < 2 || TURN_CYCLES < 1 || TURN_CYCLES > 15 || HOLD_MAX < 1) begin : g_bad_param
        $error("rv4028_bus_arbiter: parameter out of range");
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
        rv4028_sync_n #(.STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d_n  (ext_busrq_n[i]),
            .q_n  (req_n[i])
        );
    end
    assign req = ~req_n;

`ifdef RV4028_ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0] hold_cnt;
    logic [NUM_REQ-1:0] mask;
    assign revoke  = state == GRANT && hold_cnt == HW'(HOLD_MAX - 1);
    assign req_eff = req & ~mask;
    // grant-length counter, sticky timeout and lockout of a revoked master until it lets go
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hold_cnt     <= '0;
            mask         <= '0;
            timeout_flag <= 1'b0;
        end else begin
            hold_cnt     <= state == GRANT && state_next == GRANT ? hold_cnt + HW'(1) : '0;
            mask         <= (mask & req) | (revoke ? NUM_REQ'(1) << owner : '0);
            timeout_flag <= timeout_flag | revoke;
        end
`else
    assign revoke       = 1'b0;
    assign req_eff      = req;
    assign timeout_flag = 1'b0;
`endif

    // first requesting master at or after the round-robin pointer, cyclically
    always_comb begin
        win = rr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_eff[(int'(rr) + k) % NUM_REQ]) win = OW'((int'(rr) + k) % NUM_REQ);
    end

    // next state, next owner and next round-robin pointer
    always_comb begin
        state_next = state;
        owner_next = owner;
        rr_next    = rr;
        turn_next  = '0;
        case (state)
            CPU_OWN:  state_next = |req_eff ? WAIT_ACK : CPU_OWN;
            WAIT_ACK: state_next = core_busack_n ? WAIT_ACK : |req_eff ? TURN : RETURN;
            TURN:
                if (turn_cnt != 4'(TURN_CYCLES - 1)) turn_next = turn_cnt + 4'd1;
                else if (|req_eff) begin
                    state_next = GRANT;
                    owner_next = win;
                end else state_next = RETURN;
            GRANT:
                if (!req[owner] || revoke) begin
                    state_next = TURN;
                    rr_next    = OW'((int'(owner) + 1) % NUM_REQ);
                end
            RETURN:   state_next = core_busack_n ? CPU_OWN : RETURN;
            default:  state_next = CPU_OWN;
        endcase
    end

    // state plus registered outputs, all taken from the next state so they move on the transition edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= CPU_OWN;
            rr            <= '0;
            owner         <= '0;
            turn_cnt      <= '0;
            core_busrq_n  <= 1'b1;
            core_drive_en <= 1'b1;
            grant_valid   <= 1'b0;
            ext_busack_n  <= '1;
        end else begin
            state         <= state_next;
            rr            <= rr_next;
            owner         <= owner_next;
            turn_cnt      <= turn_next;
            core_busrq_n  <= state_next inside {CPU_OWN, RETURN};
            core_drive_en <= state_next == CPU_OWN;
            grant_valid   <= state_next == GRANT;
            ext_busack_n  <= state_next == GRANT ? ~(NUM_REQ'(1) << owner_next) : '1;
        end
endmodule

// File: tb/tb_rv4028_bus_arbiter.sv
// tb_rv4028_bus_arbiter: directed and randomized self-checking bench for rv4028_bus_arbiter
module tb_rv4028_bus_arbiter;
    localparam int N = 2;
    localparam int S = 2;
    localparam int T = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] ext_busrq_n = '1;
    logic [N-1:0] ext_busack_n;
    logic core_busrq_n, core_drive_en, grant_valid, timeout_flag;
    logic core_busack_n = 1'b1;
    logic [0:0] owner;

    int checks = 0, errors = 0;
    int cyc = 16, ack_dly = 2, pend = 0, ack_fall = -1, last_fall = -1, rr_m = 0, grants = 0;
    bit chk_en = 1'b0, rand_ack = 1'b0;
    logic [N-1:0] pins [0:8191];
    logic ackh [0:8191];
    logic prev_drive, prev_busrq, prev_gv;
    logic [0:0] prev_owner;

    rv4028_bus_arbiter #(.NUM_REQ(N), .SYNC_STAGES(S), .TURN_CYCLES(T), .HOLD_MAX(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ext_busrq_n  (ext_busrq_n),
        .ext_busack_n (ext_busack_n),
        .core_busrq_n (core_busrq_n),
        .core_busack_n(core_busack_n),
        .core_drive_en(core_drive_en),
        .owner        (owner),
        .grant_valid  (grant_valid),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: record pin history, apply spec rules to the new outputs, then play the core
    task automatic step();
        @(negedge clk);
        pins[cyc] = ext_busrq_n;
        ackh[cyc] = core_busack_n;
        cyc++;
        if (chk_en) begin
            check("onehot_grant", $countones(~ext_busack_n) <= 1, 1);
            check("gv_matches_ack", grant_valid, ext_busack_n != '1);
            check("timeout_tied", timeout_flag, 0);
            if (grant_valid) check("core_released", {core_busrq_n, core_busack_n}, 0);
            if (prev_drive) begin
                check("cpu_req_busrq", core_busrq_n, pins[cyc-1-S] == '1);
                check("cpu_req_drive", core_drive_en, pins[cyc-1-S] == '1);
            end else if (prev_busrq) check("return_drive", core_drive_en, ackh[cyc-1]);
            if (!prev_busrq && core_busrq_n) check("return_no_req", pins[cyc-1-S], {N{1'b1}});
            if (!prev_gv && grant_valid) begin
                grants++;
                check("rr_winner", owner, pick(~pins[cyc-1-S], rr_m));
                check("grant_timing", cyc, last_fall > ack_fall ? last_fall + T : ack_fall + 1 + T);
            end
            if (prev_gv && !grant_valid) begin
                check("release_edge", {pins[cyc-1-S][prev_owner], pins[cyc-2-S][prev_owner]}, 2'b10);
                rr_m = (prev_owner + 1) % N;
                last_fall = cyc;
            end
        end
        prev_drive = core_drive_en;
        prev_busrq = core_busrq_n;
        prev_gv    = grant_valid;
        prev_owner = owner;
        if (core_busrq_n !== core_busack_n) begin
            pend++;
            if (pend >= ack_dly) begin
                core_busack_n = core_busrq_n;
                pend = 0;
                if (!core_busack_n) ack_fall = cyc;
                if (rand_ack) ack_dly = $urandom_range(1, 4);
            end
        end else pend = 0;
    endtask

    initial begin
        for (int k = 0; k < 8192; k++) begin
            pins[k] = '1;
            ackh[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("rst_busrq", core_busrq_n, 1);
        check("rst_ack", ext_busack_n, 2'b11);
        check("rst_drive", core_drive_en, 1);
        check("rst_owner_gv_to", {owner, grant_valid, timeout_flag}, 3'b000);
        rst_n = 1'b1;
        step();
        step();
        chk_en = 1'b1;

        ext_busrq_n = 2'b00;
        for (int n = 0; n < 40 && !grant_valid; n++) step();
        check("both_first_owner", {grant_valid, owner}, 2'b10);
        repeat (3) step();
        ext_busrq_n = 2'b01;
        for (int n = 0; n < 20 && grant_valid; n++) step();
        check("m0_released", grant_valid, 0);
        repeat (T) step();
        check("m1_after_dead", {grant_valid, owner, ext_busack_n}, {1'b1, 1'b1, 2'b01});
        repeat (4) step();
        ext_busrq_n = 2'b11;
        for (int n = 0; n < 20 && grant_valid; n++) step();
        check("m1_released", grant_valid, 0);
        for (int n = 0; n < 60 && !(core_drive_en && core_busack_n); n++) step();
        check("idle_after_m1", core_drive_en, 1);
        ext_busrq_n = 2'b00;
        for (int n = 0; n < 40 && !grant_valid; n++) step();
        check("rr_wrap_owner0", {grant_valid, owner}, 2'b10);
        ext_busrq_n = 2'b11;
        for (int n = 0; n < 60 && !(core_drive_en && core_busack_n); n++) step();
        check("idle_after_both", core_drive_en, 1);

        repeat (2) step();
        ext_busrq_n = 2'b10;
        for (int n = 1; n <= S + 1; n++) begin
            step();
            check("busrq_latency", core_busrq_n, n <= S);
        end
        for (int n = 0; n < 20 && core_busack_n; n++) step();
        for (int n = 1; n <= T + 1; n++) begin
            step();
            check("grant_latency", ext_busack_n, n <= T ? 2'b11 : 2'b10);
            check("core_off", core_drive_en, 0);
        end
        check("grant_owner0", owner, 0);

        repeat (3) step();
        ext_busrq_n = 2'b11;
        for (int n = 0; n < 20 && grant_valid; n++) step();
        check("rel_busrq_still_low", core_busrq_n, 0);
        repeat (T) step();
        check("return_busrq_high", {core_busrq_n, core_drive_en}, 2'b10);
        for (int n = 0; n < 20 && !core_busack_n; n++) step();
        check("drive_before_ack_seen", core_drive_en, 0);
        step();
        check("drive_after_ack", core_drive_en, 1);

        repeat (2) step();
        ack_dly = 6;
        ext_busrq_n = 2'b10;
        for (int n = 0; n < 20 && core_busrq_n; n++) step();
        check("wd_busrq_low", core_busrq_n, 0);
        ext_busrq_n = 2'b11;
        for (int n = 0; n < 60 && !core_drive_en; n++) begin
            step();
            check("wd_no_grant", grant_valid, 0);
        end
        check("wd_core_back", {core_drive_en, core_busrq_n}, 2'b11);
        ack_dly = 2;

        rand_ack = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            for (int m = 0; m < N; m++)
                if (ext_busrq_n[m] ? $urandom_range(0, 9) == 0 : $urandom_range(0, 11) == 0)
                    ext_busrq_n[m] = ~ext_busrq_n[m];
            step();
        end
        check("random_grants_seen", grants > 20, 1);

        ext_busrq_n = '1;
        rand_ack = 1'b0;
        ack_dly = 2;
        for (int n = 0; n < 100 && !(core_drive_en && core_busack_n); n++) step();
        check("idle_before_reset", core_drive_en, 1);
        ext_busrq_n = 2'b01;
        for (int n = 0; n < 40 && !grant_valid; n++) step();
        check("pre_reset_grant", {grant_valid, owner}, 2'b11);
        chk_en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ack", ext_busack_n, 2'b11);
        check("async_rst_busrq", core_busrq_n, 1);
        check("async_rst_drive", {core_drive_en, grant_valid, owner}, 3'b100);
        @(negedge clk);
        rst_n = 1'b1;
        ext_busrq_n = '1;
        repeat (3) step();
        check("post_rst_core_owns", {core_drive_en, core_busrq_n, grant_valid}, 3'b110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv4028_bus_arbiter.md
Name: rv4028_bus_arbiter

Overview:
- Parametrised successor to the single-requester busrq_n/busack_n bus-release path of the RV4028 FPGA tops.
- Arbitrates N external bus masters for ownership of the shared addr/data/strobe bus.
- Requests bus release from the RV4028 core and grants the bus to one master at a time, round-robin.
- Inserts a dead turnaround between drivers and returns the bus to the core when no master is requesting.
- Sits in the top level between the board busrq_n/busack_n pins and the core.

Parameters:
- NUM_REQ, 2: number of external masters (1..8).
- SYNC_STAGES, 2: synchroniser flops on each external busrq_n (>=2).
- TURN_CYCLES, 1: dead cycles with no driver between owners (1..15).
- HOLD_MAX, 1024: max grant length in cycles; used only with the optional feature.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- ext_busrq_n, input, NUM_REQ: per-master bus request, asynchronous to clk, active-low.
- ext_busack_n, output, NUM_REQ: per-master grant, active-low, at most one low.
- core_busrq_n, output, 1: release request to the core, active-low.
- core_busack_n, input, 1: core has tristated the bus, active-low.
- core_drive_en, output, 1: top-level enable for the core's pin drivers, high = core drives.
- owner, output, clog2(NUM_REQ) (min 1): index of the granted master; valid while grant_valid.
- grant_valid, output, 1: an external master holds the bus.
- timeout_flag, output, 1: sticky, a grant was revoked (optional feature only; else tied 0).

Behaviour:
- Reset values: core_busrq_n=1, ext_busack_n=all 1, core_drive_en=1, owner=0, grant_valid=0, timeout_flag=0, rr pointer=0, state=CPU_OWN. All synchroniser flops reset to 1 (idle).
- Requests: req[i] = !sync(ext_busrq_n[i]). Every decision uses synchronised values only.
- core_drive_en: registered; high only in CPU_OWN; low in every other state.
- States:
  - CPU_OWN: if any req, assert core_busrq_n=0 and go to WAIT_ACK.
  - WAIT_ACK: hold core_busrq_n=0. When core_busack_n==0: if any req, go to TURN; else go to RETURN (requester withdrew).
  - TURN: count TURN_CYCLES; no grant and no core drive. At expiry:
    - any req: pick winner = first requesting index at or after rr pointer, cyclic. Set owner, drive ext_busack_n[owner]=0, grant_valid=1, go to GRANT.
    - no req: go to RETURN.
  - GRANT: hold grant. When req[owner] drops: release ext_busack_n next edge, set rr pointer=owner+1 (mod NUM_REQ), go to TURN. Other masters' requests never preempt.
  - RETURN: core_busrq_n=1. Wait for core_busack_n==1, then go to CPU_OWN and set core_drive_en=1 on that edge.
- Latency: request pin falling -> core_busrq_n low = SYNC_STAGES+1 cycles. core_busack_n low -> ext grant = TURN_CYCLES+1 cycles.
- A request arriving during RETURN is held. It is re-evaluated in CPU_OWN, which is entered for at least one cycle.
- Simultaneous requests go to round-robin order. NUM_REQ=1 degenerates to a pass-through with turnaround.
- Async reset mid-grant drops all grants immediately and the core regains the bus on reset release.

Optional Feature:
- Macro: RV4028_ARB_TIMEOUT_EN.
- Defined:
  - GRANT counts cycles. On reaching HOLD_MAX, the grant is revoked (ext_busack_n high), timeout_flag is set sticky until reset, and the state goes to TURN.
  - The revoked master is masked until it deasserts its request, then re-arbitrates normally.
- Undefined: no counter; grants are unbounded; timeout_flag is tied 0.

Decomposition:
- Package rv4028_bus_pkg: state enum (CPU_OWN, WAIT_ACK, TURN, GRANT, RETURN) and the default TURN_CYCLES/HOLD_MAX constants.
- Sub-module rv4028_sync_n: a SYNC_STAGES-deep active-low synchroniser with reset-to-1, instantiated per request line.

Test Plan:
- Master 0 pulls ext_busrq_n[0] low with core_busack_n following 2 cycles after core_busrq_n -> core_busrq_n low at +3, ext_busack_n=2'b10 two cycles after ack, owner=0, core_drive_en=0 throughout.
- Both masters request in the same cycle with rr=0 -> master 0 granted first. After its release, master 1 is granted following exactly 1 dead cycle, and rr becomes 0 after master 1 releases.
- Master 0 requests then withdraws before core_busack_n falls -> no ext grant; state goes to RETURN and core_drive_en returns to 1 after core_busack_n rises.
- Master 0 releases with no other request -> TURN then RETURN; core_busrq_n=1; core_drive_en=1 the cycle after core_busack_n=1.
- With RV4028_ARB_TIMEOUT_EN and HOLD_MAX=16, master 1 holds indefinitely -> grant revoked at cycle 16, timeout_flag=1, master 1 not re-granted until it releases and re-requests.
- rst_n pulsed low during GRANT -> ext_busack_n all 1 and core_busrq_n=1 asynchronously; core_drive_en=1.
